// File: rtl/bt_cmd_parser.sv
// UART command-frame parser: SYNC, CMD, ARG, CHK (CHK = CMD ^ ARG).
// Bytes are taken on the rising edge of byte_valid; an inter-byte timeout drops partial frames.
module bt_cmd_parser #(
  parameter int          CLK_FREQ       = 50000000,
  parameter int          TIMEOUT_CYCLES = CLK_FREQ / 100,
  parameter logic [7:0]  SYNC_BYTE      = 8'hAA
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] byte_in,
  input  logic       byte_valid,
  output logic [7:0] cmd,
  output logic [7:0] arg,
  output logic       cmd_valid,
  output logic       frame_err,
  output logic [7:0] err_count,
  output logic       busy,
  output logic [1:0] state_dbg
);

  typedef enum logic [1:0] {
    WAIT_SYNC = 2'd0,
    GET_CMD   = 2'd1,
    GET_ARG   = 2'd2,
    GET_CHK   = 2'd3
  } state_t;

  localparam logic [23:0] TMO_LAST = 24'(TIMEOUT_CYCLES - 1);

  state_t      state, state_next;
  logic        valid_d;
  logic        accept;
  logic [23:0] tmo_cnt;
  logic [7:0]  cmd_r, arg_r;
  logic        chk_good, chk_bad, timeout;

  assign accept    = byte_valid & ~valid_d;
  assign state_dbg = state;

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= WAIT_SYNC;
    else        state <= state_next;
  end

  // Next-state logic; an accepted byte always takes priority over the timeout
  always_comb begin
    state_next = state;
    case (state)
      WAIT_SYNC: if (accept && byte_in == SYNC_BYTE) state_next = GET_CMD;
      GET_CMD:   if (accept) state_next = GET_ARG;
      GET_ARG:   if (accept) state_next = GET_CHK;
      GET_CHK:   if (accept) state_next = WAIT_SYNC;
      default:   state_next = WAIT_SYNC;
    endcase
    if (timeout) state_next = WAIT_SYNC;
  end

  // Output / event decode
  always_comb begin
    busy     = (state != WAIT_SYNC);
    chk_good = (state == GET_CHK) && accept && (byte_in == (cmd_r ^ arg_r));
    chk_bad  = (state == GET_CHK) && accept && (byte_in != (cmd_r ^ arg_r));
    timeout  = (state != WAIT_SYNC) && !accept && (tmo_cnt == TMO_LAST);
  end

  // valid_d resets high so a level already present at reset release is not a new byte
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      valid_d <= 1'b1;
      tmo_cnt <= '0;
      cmd_r   <= '0;
      arg_r   <= '0;
    end else begin
      valid_d <= byte_valid;
      if (state == WAIT_SYNC || accept) tmo_cnt <= '0;
      else                              tmo_cnt <= tmo_cnt + 24'd1;
      if (state == GET_CMD && accept) cmd_r <= byte_in;
      if (state == GET_ARG && accept) arg_r <= byte_in;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cmd       <= '0;
      arg       <= '0;
      cmd_valid <= 1'b0;
      frame_err <= 1'b0;
      err_count <= '0;
    end else begin
      cmd_valid <= chk_good;
      frame_err <= chk_bad | timeout;
      if (chk_good) begin
        cmd <= cmd_r;
        arg <= arg_r;
      end
      if ((chk_bad || timeout) && err_count != 8'hFF) err_count <= err_count + 8'd1;
    end
  end

endmodule
